// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter that sits on the single-cycle core's data port.
//
// Register window (16 bytes at BASE_ADDR; address bits [1:0] are ignored):
//   offset 0  TXDATA  write pushes Mem_WrData[7:0]; read returns 0
//   offset 1  STATUS  read  {16'b0, count[7:0], 4'b0, overflow, busy, empty, full}
//                     write with bit3=1 clears the sticky overflow flag
//   offset 2,3        read returns 0, writes ignored
//
// Ports:
//   clk, reset        system clock (rising edge), asynchronous active-high reset
//   MemWrite          store strobe from the core
//   Mem_WrAddr        load/store address
//   Mem_WrData        store data
//   rd_data, rd_hit   combinational load response (rd_hit: load inside the window)
//   tx                serial output, idle high, registered
//   busy              serialiser active or FIFO non-empty, registered
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] rd_data,
  output logic        rd_hit,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BitCntW = $clog2(CLKS_PER_BIT);
  localparam logic [BitCntW-1:0] BitCntLast = BitCntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]    CntFull    = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Address decode
  logic       hit;
  logic [1:0] offset;
  logic       push_req, ovf_clr;
  logic       unused_bits;

  assign hit         = (Mem_WrAddr[31:4] == BASE_ADDR[31:4]);
  assign offset      = Mem_WrAddr[3:2];
  assign push_req    = MemWrite & hit & (offset == 2'd0);
  assign ovf_clr     = MemWrite & hit & (offset == 2'd1) & Mem_WrData[3];
  assign unused_bits = ^{Mem_WrAddr[1:0], Mem_WrData[31:8]};

  // FIFO
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full, empty, push, pop;
  logic            overflow_q, overflow_d;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);
  // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
  assign push  = push_req & (~full | pop);

  // Serialiser
  state_e             state_q, state_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               bit_last;
  logic               tx_q, tx_d, busy_q, busy_d;

  assign bit_last = (bit_cnt_q == BitCntLast);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = fifo_q[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end
      end
      StData: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end
      end
      StStop: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          // Back-to-back frames: go straight to the next start bit.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    if (push_req && full && !pop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end

    // tx is registered from the next state so the line changes on the same edge as the state.
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != StIdle) || (count_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= Mem_WrData[7:0];
  end

  // Combinational load port
  always_comb begin
    rd_hit  = hit & ~MemWrite;
    rd_data = '0;
    if (rd_hit && offset == 2'd1) begin
      rd_data = {16'b0, 8'(count_q), 4'b0, overflow_q, busy_q, empty, full};
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
